sevenseg_scan_reader: RTL and testbench

- Receive-side counterpart of the team's BCD-to-7-segment drivers: observes active-low segment lines a..h plus active-low digit selects from a multiplexed display, and recovers per-digit BCD values and decimal points.
- Used for loop-back checking of display outputs on the board and in simulation.
- Synchronises and debounces the pads, then decodes each stable frame into a per-digit register file with valid and error status.

---
 rtl/sevenseg_scan_reader.sv | 144 ++++++++++++++
 tb/tb_sevenseg_scan_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_reader.sv
// Recovers per-digit BCD values and decimal points from a multiplexed active-low 7-segment display.
// Optional macro SEVENSEG_READER_HEX_DECODE_EN also accepts A..F glyphs as valid digits.
module sevenseg_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a,
  input  logic                    b,
  input  logic                    c,
  input  logic                    d,
  input  logic                    e,
  input  logic                    f,
  input  logic                    g,
  input  logic                    h,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clear_i,
  output logic [4*NUM_DIGITS-1:0] digit_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic [NUM_DIGITS-1:0]   valid_o,
  output logic                    capture_stb,
  output logic [2:0]              cap_idx,
  output logic                    err_pat_o,
  output logic                    err_sel_o
);

  localparam int unsigned SW = NUM_DIGITS + 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {ST_WAIT, ST_HELD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   pad, sync1, sync2, prev;
  logic            same;
  logic [NUM_DIGITS-1:0] sel_hot;
  logic [3:0]      sel_cnt;
  logic [5:0]      dec;

  // Decode result: {is_blank, is_hit, value}
  function automatic logic [5:0] seg_decode(input logic [6:0] segs);
    case (segs)
      7'h40: seg_decode = {2'b01, 4'h0};
      7'h79: seg_decode = {2'b01, 4'h1};
      7'h24: seg_decode = {2'b01, 4'h2};
      7'h30: seg_decode = {2'b01, 4'h3};
      7'h19: seg_decode = {2'b01, 4'h4};
      7'h12: seg_decode = {2'b01, 4'h5};
      7'h02: seg_decode = {2'b01, 4'h6};
      7'h78: seg_decode = {2'b01, 4'h7};
      7'h00: seg_decode = {2'b01, 4'h8};
      7'h10: seg_decode = {2'b01, 4'h9};
`ifdef SEVENSEG_READER_HEX_DECODE_EN
      7'h08: seg_decode = {2'b01, 4'hA};
      7'h03: seg_decode = {2'b01, 4'hB};
      7'h46: seg_decode = {2'b01, 4'hC};
      7'h21: seg_decode = {2'b01, 4'hD};
      7'h06: seg_decode = {2'b01, 4'hE};
      7'h0E: seg_decode = {2'b01, 4'hF};
`endif
      7'h7F: seg_decode = {2'b10, 4'hF};
      default: seg_decode = {2'b00, 4'hF};
    endcase
  endfunction

  assign pad     = {an, h, g, f, e, d, c, b, a};
  assign same    = (sync2 == prev);
  assign sel_hot = ~sync2[SW-1:8];
  assign dec     = seg_decode(sync2[6:0]);

  // Number of digit selects pulled low in the current synchronised sample
  always_comb begin
    sel_cnt = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_hot[i]) sel_cnt = sel_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      prev        <= '1;
      cnt         <= '0;
      state       <= ST_WAIT;
      digit_o     <= '1;
      dp_o        <= '0;
      valid_o     <= '0;
      capture_stb <= 1'b0;
      cap_idx     <= 3'd0;
      err_pat_o   <= 1'b0;
      err_sel_o   <= 1'b0;
    end else begin
      sync1       <= pad;
      sync2       <= sync1;
      prev        <= sync2;
      capture_stb <= 1'b0;

      // Clear first so a coincident capture's writes take precedence
      if (clear_i) begin
        valid_o   <= '0;
        err_pat_o <= 1'b0;
        err_sel_o <= 1'b0;
      end

      case (state)
        ST_WAIT: begin
          if (!same) begin
            cnt <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt   <= '0;
            state <= ST_HELD;
            if (sel_cnt == 4'd1) begin
              capture_stb <= 1'b1;
              for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_hot[i]) begin
                  cap_idx           <= 3'(i);
                  digit_o[4*i +: 4] <= dec[3:0];
                  valid_o[i]        <= dec[4];
                  if (dec[4]) dp_o[i] <= ~sync2[7];
                end
              end
              if (dec[5:4] == 2'b00) err_pat_o <= 1'b1;
            end else if (sel_cnt > 4'd1) begin
              err_sel_o <= 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (!same) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Directed bench for sevenseg_scan_reader (default parameters: 4 digits, 16 stable cycles).
module tb_sevenseg_scan_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        a, b, c, d, e, f, g, h;
  logic [3:0]  an;
  logic        clear_i;
  logic [15:0] digit_o;
  logic [3:0]  dp_o;
  logic [3:0]  valid_o;
  logic        capture_stb;
  logic [2:0]  cap_idx;
  logic        err_pat_o;
  logic        err_sel_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_stb = 0;
  int last_stb_cyc = -1;
  int e0;
  int base;

  sevenseg_scan_reader dut (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .an(an), .clear_i(clear_i),
    .digit_o(digit_o), .dp_o(dp_o), .valid_o(valid_o),
    .capture_stb(capture_stb), .cap_idx(cap_idx),
    .err_pat_o(err_pat_o), .err_sel_o(err_sel_o)
  );

  always #5 clk = ~clk;

  // Posedge counter and strobe log, sampled just after each edge
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (capture_stb) begin
      n_stb = n_stb + 1;
      last_stb_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Applies a frame at the current negedge; the next posedge is its first sampling edge
  task automatic apply(input logic [3:0] an_v, input logic [6:0] seg, input logic h_v);
    an = an_v;
    {g, f, e, d, c, b, a} = seg;
    h = h_v;
    e0 = cyc + 1;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_i = 1'b0;
    an = 4'hF;
    {h, g, f, e, d, c, b, a} = 8'hFF;
    hold(3);
    check("rst_digit", 32'(digit_o), 32'h0000FFFF);
    check("rst_dp_valid", 32'({dp_o, valid_o}), 32'h0);
    check("rst_stb_idx", 32'({capture_stb, cap_idx}), 32'h0);
    check("rst_err", 32'({err_pat_o, err_sel_o}), 32'h0);
    rst = 1'b0;
    hold(3);

    // Single static frame captures once, 2+16 edges after first sampling
    base = n_stb;
    apply(4'b1110, 7'h40, 1'b1);
    hold(40);
    check("t1_nstb", 32'(n_stb - base), 32'd1);
    check("t1_lat", 32'(last_stb_cyc), 32'(e0 + 18));
    check("t1_idx", 32'(cap_idx), 32'd0);
    check("t1_digit0", 32'(digit_o[3:0]), 32'h0);
    check("t1_valid", 32'(valid_o), 32'b0001);
    check("t1_dp", 32'(dp_o), 32'b0000);

    // Four-digit scan
    base = n_stb;
    apply(4'b1110, 7'h79, 1'b0); hold(20);
    apply(4'b1101, 7'h24, 1'b1); hold(20);
    apply(4'b1011, 7'h30, 1'b1); hold(20);
    apply(4'b0111, 7'h10, 1'b1); hold(20);
    check("t2_nstb", 32'(n_stb - base), 32'd4);
    check("t2_digit", 32'(digit_o), 32'h9321);
    check("t2_dp", 32'(dp_o), 32'b0001);
    check("t2_valid", 32'(valid_o), 32'b1111);
    check("t2_idx", 32'(cap_idx), 32'd3);

    // Short glitch between two identical stable frames
    apply(4'b1110, 7'h79, 1'b0); hold(20);
    base = n_stb;
    apply(4'b1110, 7'h24, 1'b0); hold(5);
    apply(4'b1110, 7'h79, 1'b0); hold(20);
    check("t3_nstb", 32'(n_stb - base), 32'd1);
    check("t3_lat", 32'(last_stb_cyc), 32'(e0 + 18));
    check("t3_digit", 32'(digit_o), 32'h9321);

    // Two selects low: select error, no strobe; clear drops it
    base = n_stb;
    apply(4'b1100, 7'h40, 1'b1); hold(30);
    check("t4_nstb", 32'(n_stb - base), 32'd0);
    check("t4_errsel", 32'(err_sel_o), 32'd1);
    check("t4_digit", 32'(digit_o), 32'h9321);
    clear_i = 1'b1; hold(1); clear_i = 1'b0; hold(1);
    check("t4_clr_errsel", 32'(err_sel_o), 32'd0);
    check("t4_clr_valid", 32'(valid_o), 32'b0000);
    check("t4_clr_digit", 32'(digit_o), 32'h9321);

    // Hex glyph 'A' on digit 2
    base = n_stb;
    apply(4'b1011, 7'h08, 1'b1); hold(20);
    check("t5_nstb", 32'(n_stb - base), 32'd1);
    check("t5_idx", 32'(cap_idx), 32'd2);
`ifdef SEVENSEG_READER_HEX_DECODE_EN
    check("t5_errpat", 32'(err_pat_o), 32'd0);
    check("t5_digit", 32'(digit_o), 32'h9A21);
    check("t5_valid", 32'(valid_o), 32'b0100);
`else
    check("t5_errpat", 32'(err_pat_o), 32'd1);
    check("t5_digit", 32'(digit_o), 32'h9F21);
    check("t5_valid", 32'(valid_o), 32'b0000);
`endif
    clear_i = 1'b1; hold(1); clear_i = 1'b0; hold(1);
    check("t5_clr_err", 32'({err_pat_o, err_sel_o}), 32'h0);

    // Reset with the counter at 10 discards the pending frame
    base = n_stb;
    apply(4'b1101, 7'h19, 1'b1);
    hold(13);
    rst = 1'b1; hold(1); rst = 1'b0;
    e0 = cyc + 1;
    check("t6_rst_digit", 32'(digit_o), 32'h0000FFFF);
    check("t6_rst_valid", 32'(valid_o), 32'h0);
    hold(17);
    check("t6_nostb_early", 32'(n_stb - base), 32'd0);
    hold(3);
    check("t6_nstb", 32'(n_stb - base), 32'd1);
    check("t6_lat", 32'(last_stb_cyc), 32'(e0 + 18));
    check("t6_digit", 32'(digit_o), 32'hFF4F);
    check("t6_valid", 32'(valid_o), 32'b0010);

    // Clear coinciding with a capture keeps only that digit valid
    apply(4'b1110, 7'h40, 1'b1); hold(20);
    apply(4'b0111, 7'h12, 1'b0); hold(20);
    check("t7_pre_valid", 32'(valid_o), 32'b1011);
    base = n_stb;
    apply(4'b1011, 7'h02, 1'b1);
    hold(18);
    clear_i = 1'b1; hold(1); clear_i = 1'b0;
    hold(3);
    check("t7_nstb", 32'(n_stb - base), 32'd1);
    check("t7_lat", 32'(last_stb_cyc), 32'(e0 + 18));
    check("t7_valid", 32'(valid_o), 32'b0100);
    check("t7_digit", 32'(digit_o), 32'h5640);
    check("t7_dp", 32'(dp_o), 32'b1000);
    check("t7_err", 32'({err_pat_o, err_sel_o}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
